// File: rtl/dcache_responder.sv
// Direct-mapped, two-word-block, write-back data cache responder.
// Services datapath loads/stores, fills and evicts over a single memory port, and flushes dirty lines on halt.
//
// state  | meaning
// IDLE   | service hits; a miss starts a fill, halt starts a flush
// WB0    | write back word0 of the victim line
// WB1    | write back word1 of the victim line
// LD0    | read word0 of the missing block
// LD1    | read word1, then install the line as valid/clean
// FLUSH0 | write back word0 of the flush line if dirty
// FLUSH1 | write back word1 of the flush line, then clear dirty
// FNEXT  | advance the flush index or finish
// DONE   | flush complete; held until reset
module dcache_responder #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int BLKWORDS = 2;
    localparam int OFF_W    = $clog2(BLKWORDS) + 2;
    localparam int IDX_W    = $clog2(SETS);
    localparam int TAG_W    = 32 - OFF_W - IDX_W;

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, LD0, LD1, FLUSH0, FLUSH1, FNEXT, DONE
    } state_t;

    state_t state, next_state;

    logic [SETS-1:0]  valid, dirty;
    logic [TAG_W-1:0] tags  [SETS];
    logic [31:0]      word0 [SETS];
    logic [31:0]      word1 [SETS];
    logic [IDX_W-1:0] miss_idx, fidx;
    logic [TAG_W-1:0] miss_tag;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             wsel, req, tag_hit, unused_bits;
    logic             wr_hit, capture, fill0, fill1, flush_clr, fidx_inc, fidx_clr;

    assign req_idx     = dmemaddr[OFF_W+IDX_W-1:OFF_W];
    assign req_tag     = dmemaddr[31:OFF_W+IDX_W];
    assign wsel        = dmemaddr[2];
    assign unused_bits = ^dmemaddr[1:0];
    assign req         = dmemREN | dmemWEN;
    assign tag_hit     = valid[req_idx] && (tags[req_idx] == req_tag);

    always_comb begin
        next_state = state;
        dhit       = 1'b0;
        dmemload   = '0;
        flushed    = 1'b0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        daddr      = '0;
        dstore     = '0;
        wr_hit     = 1'b0;
        capture    = 1'b0;
        fill0      = 1'b0;
        fill1      = 1'b0;
        flush_clr  = 1'b0;
        fidx_inc   = 1'b0;
        fidx_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (tag_hit) begin
                        dhit   = 1'b1;
                        wr_hit = dmemWEN;
                        if (dmemREN)
                            dmemload = wsel ? word1[req_idx] : word0[req_idx];
                    end else begin
                        capture    = 1'b1;
                        next_state = (valid[req_idx] && dirty[req_idx]) ? WB0 : LD0;
                    end
                end else if (halt) begin
                    fidx_clr   = 1'b1;
                    next_state = FLUSH0;
                end
            end
            WB0: begin
                dWEN   = 1'b1;
                daddr  = {tags[miss_idx], miss_idx, 1'b0, 2'b00};
                dstore = word0[miss_idx];
                if (!dwait) next_state = WB1;
            end
            WB1: begin
                dWEN   = 1'b1;
                daddr  = {tags[miss_idx], miss_idx, 1'b1, 2'b00};
                dstore = word1[miss_idx];
                if (!dwait) next_state = LD0;
            end
            LD0: begin
                dREN  = 1'b1;
                daddr = {miss_tag, miss_idx, 1'b0, 2'b00};
                if (!dwait) begin
                    fill0      = 1'b1;
                    next_state = LD1;
                end
            end
            LD1: begin
                dREN  = 1'b1;
                daddr = {miss_tag, miss_idx, 1'b1, 2'b00};
                if (!dwait) begin
                    fill1      = 1'b1;
                    next_state = IDLE;
                end
            end
            FLUSH0: begin
                if (valid[fidx] && dirty[fidx]) begin
                    dWEN   = 1'b1;
                    daddr  = {tags[fidx], fidx, 1'b0, 2'b00};
                    dstore = word0[fidx];
                    if (!dwait) next_state = FLUSH1;
                end else begin
                    next_state = FNEXT;
                end
            end
            FLUSH1: begin
                dWEN   = 1'b1;
                daddr  = {tags[fidx], fidx, 1'b1, 2'b00};
                dstore = word1[fidx];
                if (!dwait) begin
                    flush_clr  = 1'b1;
                    next_state = FNEXT;
                end
            end
            FNEXT: begin
                if (fidx == IDX_W'(SETS - 1)) begin
                    next_state = DONE;
                end else begin
                    fidx_inc   = 1'b1;
                    next_state = FLUSH0;
                end
            end
            DONE: flushed = 1'b1;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
            fidx  <= '0;
        end else begin
            state <= next_state;
            if (wr_hit) dirty[req_idx] <= 1'b1;
            if (fill1) begin
                valid[miss_idx] <= 1'b1;
                dirty[miss_idx] <= 1'b0;
            end
            if (flush_clr) dirty[fidx] <= 1'b0;
            if (fidx_clr)      fidx <= '0;
            else if (fidx_inc) fidx <= fidx + 1'b1;
        end
    end

    // Payload storage carries no reset; valid bits qualify every use.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (capture) begin
                miss_idx <= req_idx;
                miss_tag <= req_tag;
            end
            if (wr_hit) begin
                if (wsel) word1[req_idx] <= dmemstore;
                else      word0[req_idx] <= dmemstore;
            end
            if (fill0) word0[miss_idx] <= dload;
            if (fill1) begin
                word1[miss_idx] <= dload;
                tags[miss_idx]  <= miss_tag;
            end
        end
    end
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: fills, store hits, dirty eviction with stalls, reset mid-fill, flush on halt.
// Memory returns dload = daddr ^ K so every fetched word is predictable.
module tb_dcache_responder;
    localparam logic [31:0] K = 32'h5A5A_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        dmemREN, dmemWEN, halt, dwait;
    logic [31:0] dmemaddr, dmemstore, dload;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    int total = 0;
    int bad   = 0;

    dcache_responder #(.SETS(16)) dut (
        .CLK(CLK), .RST(RST),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;
    assign dload = daddr ^ K;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] wr_addr [8];
    logic [31:0] wr_data [8];
    int          writes, cycles, rd_seen, both_seen;

    initial begin
        RST = 1'b1; dmemREN = 0; dmemWEN = 0; halt = 0; dwait = 0;
        dmemaddr = '0; dmemstore = '0;
        step(); step();
        check("rst_dhit", dhit, 0);
        check("rst_flushed", flushed, 0);
        check("rst_dren", dREN, 0);
        check("rst_dwen", dWEN, 0);
        check("rst_daddr", daddr, 0);
        check("rst_dstore", dstore, 0);
        check("rst_dmemload", dmemload, 0);
        RST = 1'b0;
        step();

        // cold load 0x40
        dmemREN = 1; dmemaddr = 32'h40; #1;
        check("cold_miss_dhit", dhit, 0);
        step();
        check("ld0_dren", dREN, 1);
        check("ld0_dwen", dWEN, 0);
        check("ld0_daddr", daddr, 32'h40);
        step();
        check("ld1_dren", dREN, 1);
        check("ld1_daddr", daddr, 32'h44);
        step();
        check("cold_hit", dhit, 1);
        check("cold_load", dmemload, 32'h40 ^ K);
        check("cold_hit_dren", dREN, 0);

        // store hit, then read back
        dmemREN = 0; dmemWEN = 1; dmemstore = 32'hDEADBEEF; #1;
        check("st_hit", dhit, 1);
        check("st_no_dwen", dWEN, 0);
        step();
        dmemWEN = 0; dmemREN = 1; #1;
        check("st_rd_hit", dhit, 1);
        check("st_rd_data", dmemload, 32'hDEADBEEF);
        dmemaddr = 32'h44; #1;
        check("w1_rd_data", dmemload, 32'h44 ^ K);

        // conflicting load 0x440 evicts dirty set 8, with memory stalled in WB0
        dmemaddr = 32'h440; dwait = 1; #1;
        check("evict_miss", dhit, 0);
        step();
        check("wb0_dwen", dWEN, 1);
        check("wb0_dren", dREN, 0);
        check("wb0_daddr", daddr, 32'h40);
        check("wb0_dstore", dstore, 32'hDEADBEEF);
        dmemaddr = 32'h80;
        for (int i = 0; i < 4; i++) begin
            step();
            check("wb0_hold_dwen", dWEN, 1);
            check("wb0_hold_daddr", daddr, 32'h40);
            check("wb0_hold_dstore", dstore, 32'hDEADBEEF);
        end
        dwait = 0; #1;
        check("wb0_release_daddr", daddr, 32'h40);
        step();
        check("wb1_dwen", dWEN, 1);
        check("wb1_daddr", daddr, 32'h44);
        check("wb1_dstore", dstore, 32'h44 ^ K);
        dmemaddr = 32'h440;
        step();
        check("ev_ld0_dren", dREN, 1);
        check("ev_ld0_dwen", dWEN, 0);
        check("ev_ld0_daddr", daddr, 32'h440);
        step();
        check("ev_ld1_daddr", daddr, 32'h444);
        step();
        check("ev_hit", dhit, 1);
        check("ev_load", dmemload, 32'h440 ^ K);

        // reset during LD1
        dmemaddr = 32'h80; #1;
        check("s0_miss", dhit, 0);
        step();
        check("s0_ld0_daddr", daddr, 32'h80);
        step();
        check("s0_ld1_daddr", daddr, 32'h84);
        check("s0_ld1_dren", dREN, 1);
        RST = 1;
        step();
        check("rst_ld1_dren", dREN, 0);
        check("rst_ld1_dhit", dhit, 0);
        RST = 0; #1;
        check("reload_miss", dhit, 0);
        step();
        check("reload_ld0_daddr", daddr, 32'h80);
        check("reload_ld0_dren", dREN, 1);
        step();
        check("reload_ld1_daddr", daddr, 32'h84);
        step();
        check("reload_hit", dhit, 1);
        check("reload_load", dmemload, 32'h80 ^ K);

        // dirty sets 0 and 15
        dmemREN = 0; dmemWEN = 1; dmemstore = 32'h11111111; #1;
        check("s0_st_hit", dhit, 1);
        step();
        dmemaddr = 32'h7C; dmemstore = 32'h22222222; #1;
        check("s15_miss", dhit, 0);
        step();
        check("s15_ld0_daddr", daddr, 32'h78);
        step();
        check("s15_ld1_daddr", daddr, 32'h7C);
        step();
        check("s15_st_hit", dhit, 1);
        step();
        dmemWEN = 0; halt = 1;

        writes = 0; cycles = 0; rd_seen = 0; both_seen = 0;
        while (!flushed && cycles < 200) begin
            step();
            cycles++;
            if (dREN) rd_seen++;
            if (dREN && dWEN) both_seen++;
            if (dWEN) begin
                if (writes < 8) begin
                    wr_addr[writes] = daddr;
                    wr_data[writes] = dstore;
                end
                writes++;
            end
        end
        check("flush_done", flushed, 1);
        check("flush_cycles", cycles, 35);
        check("flush_writes", writes, 4);
        check("flush_no_reads", rd_seen, 0);
        check("flush_no_both", both_seen, 0);
        if (writes == 4) begin
            check("fw0_addr", wr_addr[0], 32'h80);
            check("fw0_data", wr_data[0], 32'h11111111);
            check("fw1_addr", wr_addr[1], 32'h84);
            check("fw1_data", wr_data[1], 32'h84 ^ K);
            check("fw2_addr", wr_addr[2], 32'h78);
            check("fw2_data", wr_data[2], 32'h78 ^ K);
            check("fw3_addr", wr_addr[3], 32'h7C);
            check("fw3_data", wr_data[3], 32'h22222222);
        end

        // DONE holds and ignores requests
        dmemREN = 1; dmemaddr = 32'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            check("done_flushed", flushed, 1);
            check("done_dhit", dhit, 0);
            check("done_dren", dREN, 0);
            check("done_dwen", dWEN, 0);
        end
        dmemREN = 0; halt = 0; RST = 1;
        step();
        RST = 0; #1;
        check("post_rst_flushed", flushed, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
